// File: rtl/reg_trace_banked.sv
// Trace-trigger register block with banked, shadowed pattern/mask storage,
// atomic commit to the live trigger copy, and per-rule saturating match counters
// read coherently through a snapshot taken on the byte-0 access.
module reg_trace_banked #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pBUFFER_SIZE  = 64,
  parameter int unsigned pMATCH_RULES  = 8,
  parameter int unsigned pCOUNT_WIDTH  = 16,
  parameter logic [1:0]  pREG_SELECT   = 2'b00
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_i,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  output logic                                   selected,
  output logic [4:0]                             O_clksettings,
  output logic [pMATCH_RULES-1:0]                O_pattern_enable,
  output logic [pMATCH_RULES-1:0]                O_pattern_trig_enable,
  output logic                                   O_trace_reset_sync,
  output logic                                   O_soft_trig_passthru,
  output logic                                   O_soft_trig_enable,
  output logic                                   O_capture_raw,
  output logic                                   O_record_syncs,
  output logic [2:0]                             O_trace_width,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_pattern,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_mask,
  output logic                                   O_commit,
  input  logic                                   I_synchronized,
  input  logic [pMATCH_RULES-1:0]                I_match_pulse,
  input  logic [pBUFFER_SIZE-1:0]                I_matched_data
);

  localparam int unsigned BufBytes = pBUFFER_SIZE / 8;
  localparam int unsigned CntBytes = pCOUNT_WIDTH / 8;
  localparam logic [63:0] Name = 64'h32_42_63_72_54_6D_72_41;  // "ArmTrcB2", 'A' in byte 0

  localparam logic [5:0] AddrName = 6'h00, AddrRev = 6'h01, AddrClk = 6'h02, AddrPatEn = 6'h03;
  localparam logic [5:0] AddrTrigEn = 6'h04, AddrRstSync = 6'h05, AddrWidth = 6'h06;
  localparam logic [5:0] AddrPassthru = 6'h07, AddrSoftEn = 6'h08, AddrRaw = 6'h09;
  localparam logic [5:0] AddrRecSync = 6'h0A, AddrSync = 6'h0B, AddrRuleSel = 6'h0C;
  localparam logic [5:0] AddrPattern = 6'h0D, AddrMask = 6'h0E, AddrCommit = 6'h0F;
  localparam logic [5:0] AddrCount = 6'h10, AddrClear = 6'h11, AddrMatched = 6'h12;
  localparam logic [5:0] AddrNumRules = 6'h13, AddrBufBytes = 6'h14;

  logic [7:0]                 read_data_q, read_data_d, rd_byte;
  logic [4:0]                 clk_q, clk_d, rule_sel_q, rule_sel_d;
  logic [pMATCH_RULES-1:0]    pat_en_q, pat_en_d, trig_en_q, trig_en_d;
  logic                       rst_sync_q, rst_sync_d, passthru_q, passthru_d;
  logic                       soft_en_q, soft_en_d, raw_q, raw_d, rec_sync_q, rec_sync_d;
  logic [2:0]                 width_q, width_d;
  logic                       dirty_q, dirty_d, commit_q, commit_d, count_clear;
  logic [pBUFFER_SIZE-1:0]    shadow_pat_q [pMATCH_RULES], shadow_pat_d [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0]    shadow_mask_q [pMATCH_RULES], shadow_mask_d [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0]    live_pat_q [pMATCH_RULES], live_pat_d [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0]    live_mask_q [pMATCH_RULES], live_mask_d [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0]    cnt_q [pMATCH_RULES], cnt_d [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0]    snap_q, snap_d;

  logic [5:0]  offset;
  logic        rd_en, wr_en, byte0, rule_ok;
  int unsigned bc_idx, rs_idx;
  logic        unused_bits;

  assign offset      = reg_address[5:0];
  assign selected    = reg_addrvalid & (reg_address[7:6] == pREG_SELECT);
  assign rd_en       = selected & reg_read;
  assign wr_en       = selected & reg_write;
  assign bc_idx      = 32'(reg_bytecnt);
  assign rs_idx      = 32'(rule_sel_q);
  assign byte0       = (reg_bytecnt == '0);
  assign rule_ok     = (rs_idx < pMATCH_RULES);
  // Snapshot byte 0 is never read back: byte 0 always comes from the live counter.
  assign unused_bits = ^{reg_address[pADDR_WIDTH-pBYTECNT_SIZE-1:8], snap_q[7:0]};

  // Addressed read byte; anything unmapped or out of range reads as zero.
  always_comb begin
    rd_byte = '0;
    case (offset)
      AddrName:     for (int unsigned b = 0; b < 8; b++) if (b == bc_idx) rd_byte = Name[b*8 +: 8];
      AddrRev:      if (byte0) rd_byte = 8'h02;
      AddrClk:      if (byte0) rd_byte = {3'b0, clk_q};
      AddrPatEn:    for (int unsigned i = 0; i < pMATCH_RULES; i++)
                      if (i / 8 == bc_idx) rd_byte[i % 8] = pat_en_q[i];
      AddrTrigEn:   for (int unsigned i = 0; i < pMATCH_RULES; i++)
                      if (i / 8 == bc_idx) rd_byte[i % 8] = trig_en_q[i];
      AddrRstSync:  if (byte0) rd_byte = {7'b0, rst_sync_q};
      AddrWidth:    if (byte0) rd_byte = {5'b0, width_q};
      AddrPassthru: if (byte0) rd_byte = {7'b0, passthru_q};
      AddrSoftEn:   if (byte0) rd_byte = {7'b0, soft_en_q};
      AddrRaw:      if (byte0) rd_byte = {7'b0, raw_q};
      AddrRecSync:  if (byte0) rd_byte = {7'b0, rec_sync_q};
      AddrSync:     if (byte0) rd_byte = {7'b0, I_synchronized};
      AddrRuleSel:  if (byte0) rd_byte = {3'b0, rule_sel_q};
      AddrPattern, AddrMask: begin
        for (int unsigned r = 0; r < pMATCH_RULES; r++) begin
          for (int unsigned b = 0; b < BufBytes; b++) begin
            if (r == rs_idx && b == bc_idx) begin
              rd_byte = (offset == AddrPattern) ? shadow_pat_q[r][b*8 +: 8]
                                                : shadow_mask_q[r][b*8 +: 8];
            end
          end
        end
      end
      AddrCommit:   if (byte0) rd_byte = {7'b0, dirty_q};
      AddrCount: begin
        for (int unsigned r = 0; r < pMATCH_RULES; r++) begin
          if (r == rs_idx && byte0) rd_byte = cnt_q[r][7:0];
        end
        for (int unsigned b = 1; b < CntBytes; b++) begin
          if (rule_ok && b == bc_idx) rd_byte = snap_q[b*8 +: 8];
        end
      end
      AddrMatched:  for (int unsigned b = 0; b < BufBytes; b++)
                      if (b == bc_idx) rd_byte = I_matched_data[b*8 +: 8];
      AddrNumRules: if (byte0) rd_byte = 8'(pMATCH_RULES);
      AddrBufBytes: if (byte0) rd_byte = 8'(BufBytes);
      default:      rd_byte = '0;
    endcase
  end

  // Next-state for host writes, commit, snapshot capture and match counters.
  always_comb begin
    read_data_d   = rd_en ? rd_byte : 8'h00;
    clk_d         = clk_q;
    rule_sel_d    = rule_sel_q;
    pat_en_d      = pat_en_q;
    trig_en_d     = trig_en_q;
    rst_sync_d    = rst_sync_q;
    passthru_d    = passthru_q;
    soft_en_d     = soft_en_q;
    raw_d         = raw_q;
    rec_sync_d    = rec_sync_q;
    width_d       = width_q;
    dirty_d       = dirty_q;
    commit_d      = 1'b0;
    count_clear   = 1'b0;
    shadow_pat_d  = shadow_pat_q;
    shadow_mask_d = shadow_mask_q;
    live_pat_d    = live_pat_q;
    live_mask_d   = live_mask_q;
    snap_d        = snap_q;
    if (wr_en) begin
      case (offset)
        AddrClk:      if (byte0) clk_d = write_data[4:0];
        AddrPatEn:    for (int unsigned i = 0; i < pMATCH_RULES; i++)
                        if (i / 8 == bc_idx) pat_en_d[i] = write_data[i % 8];
        AddrTrigEn:   for (int unsigned i = 0; i < pMATCH_RULES; i++)
                        if (i / 8 == bc_idx) trig_en_d[i] = write_data[i % 8];
        AddrRstSync:  if (byte0) rst_sync_d = write_data[0];
        AddrWidth:    if (byte0) width_d = write_data[2:0];
        AddrPassthru: if (byte0) passthru_d = write_data[0];
        AddrSoftEn:   if (byte0) soft_en_d = write_data[0];
        AddrRaw:      if (byte0) raw_d = write_data[0];
        AddrRecSync:  if (byte0) rec_sync_d = write_data[0];
        AddrRuleSel:  if (byte0) rule_sel_d = write_data[4:0];
        AddrPattern, AddrMask: begin
          for (int unsigned r = 0; r < pMATCH_RULES; r++) begin
            for (int unsigned b = 0; b < BufBytes; b++) begin
              if (r == rs_idx && b == bc_idx) begin
                if (offset == AddrPattern) shadow_pat_d[r][b*8 +: 8] = write_data;
                else                       shadow_mask_d[r][b*8 +: 8] = write_data;
                dirty_d = 1'b1;
              end
            end
          end
        end
        AddrCommit: begin
          if (byte0 && write_data[0]) begin
            live_pat_d  = shadow_pat_q;
            live_mask_d = shadow_mask_q;
            dirty_d     = 1'b0;
            commit_d    = 1'b1;
          end
        end
        AddrClear:    if (byte0 && write_data[0]) count_clear = 1'b1;
        default:      ;
      endcase
    end
    // Byte-0 count read freezes the whole count so later bytes stay coherent.
    if (rd_en && offset == AddrCount && byte0) begin
      for (int unsigned r = 0; r < pMATCH_RULES; r++) if (r == rs_idx) snap_d = cnt_q[r];
    end
    for (int unsigned r = 0; r < pMATCH_RULES; r++) begin
      if (count_clear)                           cnt_d[r] = '0;
      else if (I_match_pulse[r] && cnt_q[r] != '1) cnt_d[r] = cnt_q[r] + 1'b1;
      else                                       cnt_d[r] = cnt_q[r];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      read_data_q <= '0;
      clk_q       <= '0;
      rule_sel_q  <= '0;
      pat_en_q    <= '0;
      trig_en_q   <= '0;
      rst_sync_q  <= 1'b0;
      passthru_q  <= 1'b1;
      soft_en_q   <= 1'b0;
      raw_q       <= 1'b0;
      rec_sync_q  <= 1'b0;
      width_q     <= 3'd4;
      dirty_q     <= 1'b0;
      commit_q    <= 1'b0;
      snap_q      <= '0;
      for (int unsigned r = 0; r < pMATCH_RULES; r++) begin
        shadow_pat_q[r]  <= '0;
        shadow_mask_q[r] <= '1;
        live_pat_q[r]    <= '0;
        live_mask_q[r]   <= '1;
        cnt_q[r]         <= '0;
      end
    end else begin
      read_data_q   <= read_data_d;
      clk_q         <= clk_d;
      rule_sel_q    <= rule_sel_d;
      pat_en_q      <= pat_en_d;
      trig_en_q     <= trig_en_d;
      rst_sync_q    <= rst_sync_d;
      passthru_q    <= passthru_d;
      soft_en_q     <= soft_en_d;
      raw_q         <= raw_d;
      rec_sync_q    <= rec_sync_d;
      width_q       <= width_d;
      dirty_q       <= dirty_d;
      commit_q      <= commit_d;
      snap_q        <= snap_d;
      shadow_pat_q  <= shadow_pat_d;
      shadow_mask_q <= shadow_mask_d;
      live_pat_q    <= live_pat_d;
      live_mask_q   <= live_mask_d;
      cnt_q         <= cnt_d;
    end
  end

  for (genvar r = 0; r < pMATCH_RULES; r++) begin : g_live
    assign O_trace_pattern[r*pBUFFER_SIZE +: pBUFFER_SIZE] = live_pat_q[r];
    assign O_trace_mask[r*pBUFFER_SIZE +: pBUFFER_SIZE]    = live_mask_q[r];
  end

  assign read_data             = read_data_q;
  assign O_clksettings         = clk_q;
  assign O_pattern_enable      = pat_en_q;
  assign O_pattern_trig_enable = trig_en_q;
  assign O_trace_reset_sync    = rst_sync_q;
  assign O_soft_trig_passthru  = passthru_q;
  assign O_soft_trig_enable    = soft_en_q;
  assign O_capture_raw         = raw_q;
  assign O_record_syncs        = rec_sync_q;
  assign O_trace_width         = width_q;
  assign O_commit              = commit_q;

endmodule

// File: tb/tb_reg_trace_banked.sv
// Bench for reg_trace_banked: directed literal checks plus randomized traffic,
// all outputs compared every cycle against a register-level reference model.
module tb_reg_trace_banked;

  localparam int R  = 8;
  localparam int BW = 64;
  localparam int BB = BW / 8;
  localparam int EB = (R + 7) / 8;
  localparam int CW = 16;
  localparam int CB = CW / 8;
  localparam int AW = 14;
  localparam logic [63:0] NAME = 64'h32_42_63_72_54_6D_72_41;

  logic            usb_clk = 1'b0;
  logic            reset_i;
  logic [AW-1:0]   reg_address;
  logic [6:0]      reg_bytecnt;
  logic [7:0]      write_data, read_data;
  logic            reg_read, reg_write, reg_addrvalid, selected;
  logic [4:0]      O_clksettings;
  logic [R-1:0]    O_pattern_enable, O_pattern_trig_enable;
  logic            O_trace_reset_sync, O_soft_trig_passthru, O_soft_trig_enable;
  logic            O_capture_raw, O_record_syncs, O_commit;
  logic [2:0]      O_trace_width;
  logic [R*BW-1:0] O_trace_pattern, O_trace_mask;
  logic            I_synchronized;
  logic [R-1:0]    I_match_pulse;
  logic [BW-1:0]   I_matched_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 usb_clk = ~usb_clk;

  reg_trace_banked dut (
    .usb_clk(usb_clk), .reset_i(reset_i), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .write_data(write_data), .read_data(read_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .selected(selected), .O_clksettings(O_clksettings), .O_pattern_enable(O_pattern_enable),
    .O_pattern_trig_enable(O_pattern_trig_enable), .O_trace_reset_sync(O_trace_reset_sync),
    .O_soft_trig_passthru(O_soft_trig_passthru), .O_soft_trig_enable(O_soft_trig_enable),
    .O_capture_raw(O_capture_raw), .O_record_syncs(O_record_syncs),
    .O_trace_width(O_trace_width), .O_trace_pattern(O_trace_pattern),
    .O_trace_mask(O_trace_mask), .O_commit(O_commit), .I_synchronized(I_synchronized),
    .I_match_pulse(I_match_pulse), .I_matched_data(I_matched_data)
  );

  // ---------------- reference model ----------------
  logic [4:0]      m_clk;
  logic [R-1:0]    m_pen, m_pten;
  logic            m_trs, m_stp, m_ste, m_raw, m_rsync, m_dirty, m_commit;
  logic [2:0]      m_tw;
  int              m_rsel;
  logic [BW-1:0]   m_spat [R];
  logic [BW-1:0]   m_smask [R];
  logic [R*BW-1:0] m_lpat, m_lmask;
  int unsigned     m_cnt [R];
  int unsigned     m_snap;
  logic [7:0]      m_rd;
  bit              model_ok = 1'b0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clk = '0; m_pen = '0; m_pten = '0; m_trs = 0; m_tw = 3'd4; m_stp = 1; m_ste = 0;
    m_raw = 0; m_rsync = 0; m_rsel = 0; m_dirty = 0; m_commit = 0; m_snap = 0; m_rd = '0;
    m_lpat = '0; m_lmask = '1;
    for (int r = 0; r < R; r++) begin
      m_spat[r] = '0; m_smask[r] = '1; m_cnt[r] = 0;
    end
  endtask

  // Register contents as a whole little-endian value plus its byte length.
  task automatic reg_view(input int off, output logic [255:0] v, output int n);
    v = '0; n = 1;
    case (off)
      'h00: begin v = 256'(NAME); n = 8; end
      'h01: v = 256'(8'h02);
      'h02: v = 256'(m_clk);
      'h03: begin v = 256'(m_pen); n = EB; end
      'h04: begin v = 256'(m_pten); n = EB; end
      'h05: v = 256'(m_trs);
      'h06: v = 256'(m_tw);
      'h07: v = 256'(m_stp);
      'h08: v = 256'(m_ste);
      'h09: v = 256'(m_raw);
      'h0A: v = 256'(m_rsync);
      'h0B: v = 256'(I_synchronized);
      'h0C: v = 256'(m_rsel);
      'h0D: begin n = BB; if (m_rsel < R) v = 256'(m_spat[m_rsel]); end
      'h0E: begin n = BB; if (m_rsel < R) v = 256'(m_smask[m_rsel]); end
      'h0F: v = 256'(m_dirty);
      'h12: begin v = 256'(I_matched_data); n = BB; end
      'h13: v = 256'(R);
      'h14: v = 256'(BB);
      default: n = 0;
    endcase
  endtask

  task automatic model_step();
    int off, bc, n;
    logic [255:0] v;
    logic [7:0] nrd, wd;
    logic [EB*8-1:0] t;
    int unsigned nsnap;
    bit sel, clr, cmt;
    if (reset_i) begin
      model_reset();
      model_ok = 1'b1;
      return;
    end
    sel = reg_addrvalid && (reg_address[7:6] == 2'b00);
    off = int'(reg_address[5:0]); bc = int'(reg_bytecnt); wd = write_data;
    nrd = '0; nsnap = m_snap; clr = 0; cmt = 0;
    if (sel && reg_read) begin
      if (off == 'h10) begin
        if (m_rsel < R) begin
          if (bc == 0) begin nrd = 8'(m_cnt[m_rsel]); nsnap = m_cnt[m_rsel]; end
          else if (bc < CB) nrd = 8'(m_snap >> (8 * bc));
        end
      end else begin
        reg_view(off, v, n);
        if (bc < n) nrd = 8'(v >> (8 * bc));
      end
    end
    if (sel && reg_write) begin
      case (off)
        'h02: if (bc == 0) m_clk = wd[4:0];
        'h03: if (bc < EB) begin t = '0; t[R-1:0] = m_pen; t[bc*8 +: 8] = wd; m_pen = t[R-1:0]; end
        'h04: if (bc < EB) begin t = '0; t[R-1:0] = m_pten; t[bc*8 +: 8] = wd; m_pten = t[R-1:0]; end
        'h05: if (bc == 0) m_trs = wd[0];
        'h06: if (bc == 0) m_tw = wd[2:0];
        'h07: if (bc == 0) m_stp = wd[0];
        'h08: if (bc == 0) m_ste = wd[0];
        'h09: if (bc == 0) m_raw = wd[0];
        'h0A: if (bc == 0) m_rsync = wd[0];
        'h0C: if (bc == 0) m_rsel = int'(wd[4:0]);
        'h0D: if (m_rsel < R && bc < BB) begin m_spat[m_rsel][bc*8 +: 8] = wd; m_dirty = 1; end
        'h0E: if (m_rsel < R && bc < BB) begin m_smask[m_rsel][bc*8 +: 8] = wd; m_dirty = 1; end
        'h0F: if (bc == 0 && wd[0]) begin
                for (int r = 0; r < R; r++) begin
                  m_lpat[r*BW +: BW] = m_spat[r]; m_lmask[r*BW +: BW] = m_smask[r];
                end
                m_dirty = 0; cmt = 1;
              end
        'h11: if (bc == 0 && wd[0]) clr = 1;
        default: ;
      endcase
    end
    for (int r = 0; r < R; r++) begin
      if (clr) m_cnt[r] = 0;
      else if (I_match_pulse[r] && m_cnt[r] < (1 << CW) - 1) m_cnt[r] = m_cnt[r] + 1;
    end
    m_snap = nsnap; m_rd = nrd; m_commit = cmt;
    model_ok = 1'b1;
  endtask

  // Every cycle: all DUT outputs against the model.
  always @(negedge usb_clk) begin
    if (model_ok) begin
      chk("read_data", read_data, m_rd);
      chk("selected", selected, reg_addrvalid && reg_address[7:6] == 2'b00);
      chk("O_commit", O_commit, m_commit);
      chk("O_clksettings", O_clksettings, m_clk);
      chk("O_pattern_enable", O_pattern_enable, m_pen);
      chk("O_pattern_trig_enable", O_pattern_trig_enable, m_pten);
      chk("ctrl_bits", {O_trace_reset_sync, O_soft_trig_passthru, O_soft_trig_enable,
                        O_capture_raw, O_record_syncs}, {m_trs, m_stp, m_ste, m_raw, m_rsync});
      chk("O_trace_width", O_trace_width, m_tw);
      chk("O_trace_pattern", O_trace_pattern, m_lpat);
      chk("O_trace_mask", O_trace_mask, m_lmask);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge usb_clk);
    model_step();
    @(negedge usb_clk);
    #2;
  endtask

  task automatic do_write(input int off, input int bc, input logic [7:0] d);
    reg_addrvalid = 1; reg_address = AW'(off); reg_bytecnt = 7'(bc);
    write_data = d; reg_write = 1;
    tick();
    reg_write = 0;
  endtask

  task automatic do_read(input int off, input int bc, output logic [7:0] d);
    reg_addrvalid = 1; reg_address = AW'(off); reg_bytecnt = 7'(bc); reg_read = 1;
    tick();
    d = read_data;
    reg_read = 0;
  endtask

  logic [7:0] d;
  logic [7:0] exp_name [8];

  initial begin
    exp_name = '{8'h41, 8'h72, 8'h6D, 8'h54, 8'h72, 8'h63, 8'h42, 8'h32};
    reset_i = 1; reg_address = '0; reg_bytecnt = '0; write_data = '0; reg_read = 0;
    reg_write = 0; reg_addrvalid = 0; I_synchronized = 0; I_match_pulse = '0;
    I_matched_data = '0;
    @(negedge usb_clk); #2;
    tick(); tick();
    reset_i = 0;
    tick();

    // Reset values
    chk("rst_width", O_trace_width, 3'd4);
    chk("rst_passthru", O_soft_trig_passthru, 1'b1);
    chk("rst_mask", O_trace_mask, {(R*BW){1'b1}});
    chk("rst_pattern", O_trace_pattern, '0);
    chk("rst_read", read_data, 8'h00);

    for (int b = 0; b < 8; b++) begin
      do_read(0, b, d);
      chk("name_byte", d, exp_name[b]);
    end
    reg_addrvalid = 0; reg_read = 1;
    tick();
    chk("unselected_read", read_data, 8'h00);
    reg_read = 0; reg_addrvalid = 1;

    // Shadow write then atomic commit of rule 3
    do_write('h0C, 0, 8'd3);
    for (int b = 0; b < 8; b++) do_write('h0D, b, 8'(8'h11 * (b + 1)));
    chk("pattern_pre_commit", O_trace_pattern[3*BW +: BW], 64'h0);
    do_read('h0F, 0, d);
    chk("dirty_set", d, 8'h01);
    do_write('h0F, 0, 8'h01);
    chk("pattern_committed", O_trace_pattern[3*BW +: BW], 64'h8877665544332211);
    chk("commit_pulse", O_commit, 1'b1);
    tick();
    chk("commit_pulse_end", O_commit, 1'b0);
    do_read('h0F, 0, d);
    chk("dirty_clear", d, 8'h00);

    // Out-of-range rule select
    do_write('h0C, 0, 8'd8);
    do_write('h0D, 0, 8'hFF);
    do_read('h0F, 0, d);
    chk("oor_dirty", d, 8'h00);
    do_read('h0D, 0, d);
    chk("oor_pattern_read", d, 8'h00);

    // Counter and coherent snapshot
    do_write('h0C, 0, 8'd2);
    I_match_pulse = 8'h04;
    repeat (300) tick();
    I_match_pulse = '0;
    do_read('h10, 0, d); chk("count300_b0", d, 8'h2C);
    do_read('h10, 1, d); chk("count300_b1", d, 8'h01);
    I_match_pulse = 8'h04;
    repeat (211) tick();
    do_read('h10, 0, d); chk("count511_b0", d, 8'hFF);
    do_read('h10, 1, d); chk("snapshot_b1", d, 8'h01);
    I_match_pulse = '0;

    // Saturation and clear priority
    do_write('h0C, 0, 8'd0);
    I_match_pulse = 8'h01;
    repeat (65537) tick();
    I_match_pulse = '0;
    do_read('h10, 0, d); chk("sat_b0", d, 8'hFF);
    do_read('h10, 1, d); chk("sat_b1", d, 8'hFF);
    I_match_pulse = 8'h01;
    do_write('h11, 0, 8'h01);
    I_match_pulse = '0;
    do_read('h10, 0, d); chk("clear_b0", d, 8'h00);

    // Reset in the middle of a write
    do_write('h06, 0, 8'd2);
    chk("width_written", O_trace_width, 3'd2);
    reg_address = AW'('h0E); reg_bytecnt = '0; write_data = 8'h00; reg_write = 1;
    reset_i = 1;
    tick();
    reset_i = 0; reg_write = 0;
    chk("reset_width", O_trace_width, 3'd4);
    chk("reset_mask", O_trace_mask, {(R*BW){1'b1}});
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] off;
      off = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 21));
      reg_addrvalid  = ($urandom_range(0, 9) != 0);
      reg_address    = {6'b0, ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00, off};
      reg_bytecnt    = 7'($urandom_range(0, 9));
      reg_read       = 1'($urandom);
      reg_write      = ($urandom_range(0, 2) == 0);
      write_data     = (off == 6'h0C) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      I_match_pulse  = R'($urandom);
      I_synchronized = 1'($urandom);
      I_matched_data = {$urandom, $urandom};
      reset_i        = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset_i = 0; reg_read = 0; reg_write = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
